// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared funct3 constants, FSM/class encodings and small helpers
// for the iterative RV32M multiply/divide execute unit.
package ex_muldiv_pkg;

    // RV32M funct3 encodings.
    localparam logic [2:0] EXE_MD_MUL    = 3'b000;
    localparam logic [2:0] EXE_MD_MULH   = 3'b001;
    localparam logic [2:0] EXE_MD_MULHSU = 3'b010;
    localparam logic [2:0] EXE_MD_MULHU  = 3'b011;
    localparam logic [2:0] EXE_MD_DIV    = 3'b100;
    localparam logic [2:0] EXE_MD_DIVU   = 3'b101;
    localparam logic [2:0] EXE_MD_REM    = 3'b110;
    localparam logic [2:0] EXE_MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_CALC  = 2'b01,
        MD_FIXUP = 2'b10,
        MD_DONE  = 2'b11
    } md_state_e;

    // Signedness class: ops in one class share the same full-width result.
    typedef enum logic [2:0] {
        MD_CLS_MUL_UU = 3'd0,
        MD_CLS_MUL_SS = 3'd1,
        MD_CLS_MUL_SU = 3'd2,
        MD_CLS_DIV_S  = 3'd3,
        MD_CLS_DIV_U  = 3'd4
    } md_cls_e;

    localparam int MD_MAX_XLEN = 64;

    // Most negative two's-complement value for an xlen-bit word (caller truncates).
    function automatic logic [MD_MAX_XLEN-1:0] md_min_int(input int unsigned xlen);
        return {{(MD_MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
    endfunction

    function automatic logic md_rs1_signed(input logic [2:0] op);
        return (op == EXE_MD_MULH) || (op == EXE_MD_MULHSU) ||
               (op == EXE_MD_DIV)  || (op == EXE_MD_REM);
    endfunction

    function automatic logic md_rs2_signed(input logic [2:0] op);
        return (op == EXE_MD_MULH) || (op == EXE_MD_DIV) || (op == EXE_MD_REM);
    endfunction

    function automatic md_cls_e md_class(input logic [2:0] op);
        md_cls_e cls;
        case (op)
            EXE_MD_MULH:             cls = MD_CLS_MUL_SS;
            EXE_MD_MULHSU:           cls = MD_CLS_MUL_SU;
            EXE_MD_DIV, EXE_MD_REM:  cls = MD_CLS_DIV_S;
            EXE_MD_DIVU, EXE_MD_REMU: cls = MD_CLS_DIV_U;
            default:                 cls = MD_CLS_MUL_UU;
        endcase
        return cls;
    endfunction

    function automatic logic md_is_mul_cls(input md_cls_e cls);
        return cls inside {MD_CLS_MUL_UU, MD_CLS_MUL_SS, MD_CLS_MUL_SU};
    endfunction

endpackage

// File: rtl/ex_md_step.sv
// ex_md_step: one radix-2 iteration on the 2*XLEN accumulator.
// Multiply: {hi,lo} holds {partial product, remaining multiplier}; add-or-skip then shift right.
// Divide:   {hi,lo} holds {partial remainder, dividend/quotient}; shift left then trial subtract.
module ex_md_step
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_trial;

    // Compute both step flavours and pick the one for the current op.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
        w_trial  = w_rem_sh - {1'b0, i_opnd};
        if (i_is_div) begin
            // Borrow (top bit set) means the divisor did not fit: restore.
            if (!w_trial[XLEN]) o_acc = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            else                o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
        end else begin
            o_acc = {w_sum, i_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in EX, one op at a time,
// radix-2 over XLEN cycles with a sign fix-up cycle and a one-cycle result pulse.
// Optional feature: define EX_MD_RESULT_CACHE_EN for a one-entry result cache.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            start_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o
);

    localparam logic [XLEN-1:0] MIN_INT = XLEN'(md_min_int(XLEN));

    md_state_e         r_state, w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [4:0]        r_wd;
    logic [4:0]        r_wd_out;
    logic              r_wreg;
    logic [XLEN-1:0]   r_wdata;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_neg_hi;   // product sign (MUL) or remainder sign (DIV)
    logic              r_neg_lo;   // quotient sign (DIV)

    logic              w_accept;
    logic              w_s1, w_s2;
    logic [XLEN-1:0]   w_mag1, w_mag2;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_res;
    logic [2*XLEN-1:0] w_step_acc;
    logic [XLEN-1:0]   w_quo, w_rem;
    logic [2*XLEN-1:0] w_fix_full;

    // MUL and DIV/DIVU return the low word; the rest return the high word.
    function automatic logic [XLEN-1:0] pick_result(input logic [2:0] op,
                                                    input logic [2*XLEN-1:0] full);
        logic take_low;
        take_low = (op == EXE_MD_MUL) || (op == EXE_MD_DIV) || (op == EXE_MD_DIVU);
        return take_low ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    endfunction

    ex_md_step #(.XLEN(XLEN)) u_step (
        .i_is_div (r_op[2]),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc)
    );

    assign w_accept = start_i && ready_o && !flush_i;
    assign wreg_o   = valid_o && r_wreg;
    assign wd_o     = r_wd_out;
    assign wdata_o  = r_wdata;

    // Decode the incoming op: operand signs, magnitudes and the divide special cases.
    always_comb begin
        w_s1          = md_rs1_signed(op_i) & reg1_i[XLEN-1];
        w_s2          = md_rs2_signed(op_i) & reg2_i[XLEN-1];
        w_mag1        = w_s1 ? -reg1_i : reg1_i;
        w_mag2        = w_s2 ? -reg2_i : reg2_i;
        w_special     = 1'b0;
        w_special_res = '0;
        if (op_i[2]) begin
            if (reg2_i == '0) begin
                w_special     = 1'b1;
                w_special_res = op_i[1] ? reg1_i : '1;
            end else if (!op_i[0] && reg1_i == MIN_INT && reg2_i == '1) begin
                w_special     = 1'b1;
                w_special_res = op_i[1] ? '0 : MIN_INT;
            end
        end
    end

    // Apply the result signs to the magnitude product or quotient/remainder.
    always_comb begin
        w_quo = r_neg_lo ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem = r_neg_hi ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        if (r_op[2]) w_fix_full = {w_rem, w_quo};
        else         w_fix_full = r_neg_hi ? -r_acc : r_acc;
    end

`ifdef EX_MD_RESULT_CACHE_EN
    logic              r_c_valid;
    logic [XLEN-1:0]   r_c_op1, r_c_op2;
    md_cls_e           r_c_cls;
    logic [2*XLEN-1:0] r_c_full;
    logic [XLEN-1:0]   r_raw1, r_raw2;
    md_cls_e           r_cls;
    logic              r_cacheable;
    md_cls_e           w_cls;

    // Match the presented op against the last completed one; MUL accepts any multiply class.
    always_comb begin
        w_cls     = md_class(op_i);
        w_hit     = r_c_valid && (reg1_i == r_c_op1) && (reg2_i == r_c_op2) &&
                    ((w_cls == r_c_cls) ||
                     ((op_i == EXE_MD_MUL) && md_is_mul_cls(r_c_cls)));
        w_hit_res = pick_result(op_i, r_c_full);
    end

    // Remember the accepted op, then publish it only if it is delivered unflushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid   <= 1'b0;
            r_cacheable <= 1'b0;
        end else begin
            if (r_state == MD_IDLE && w_accept) begin
                r_raw1      <= reg1_i;
                r_raw2      <= reg2_i;
                r_cls       <= w_cls;
                r_cacheable <= !w_special && !w_hit;
            end
            if (r_state == MD_DONE && r_cacheable && !flush_i) begin
                r_c_valid <= 1'b1;
                r_c_op1   <= r_raw1;
                r_c_op2   <= r_raw2;
                r_c_cls   <= r_cls;
                r_c_full  <= r_acc;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_next_state;
    end

    // Next state and handshake outputs; flush overrides everything but reset.
    always_comb begin
        w_next_state = r_state;
        ready_o      = (r_state == MD_IDLE);
        busy_o       = (r_state != MD_IDLE);
        valid_o      = 1'b0;
        case (r_state)
            MD_IDLE:  if (start_i) w_next_state = (w_special || w_hit) ? MD_DONE : MD_CALC;
            MD_CALC:  if (r_cnt == '0) w_next_state = MD_FIXUP;
            MD_FIXUP: w_next_state = MD_DONE;
            MD_DONE: begin
                valid_o      = 1'b1;
                w_next_state = MD_IDLE;
            end
            default:  w_next_state = MD_IDLE;
        endcase
        if (flush_i) begin
            w_next_state = MD_IDLE;
            valid_o      = 1'b0;
        end
    end

    // Datapath: capture on accept, iterate in CALC, fix signs and load the result in FIXUP.
    always_ff @(posedge clk) begin
        // NOTE: r_op/r_acc/r_opnd/r_neg_* are not reset; an accept always loads them before use.
        if (rst) begin
            r_cnt    <= '0;
            r_wreg   <= 1'b0;
            r_wd_out <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_op     <= op_i;
                        r_wd     <= wd_i;
                        r_wreg   <= wreg_i;
                        r_cnt    <= CNT_W'(XLEN - 1);
                        r_neg_lo <= w_s1 ^ w_s2;
                        if (op_i[2]) begin
                            r_acc    <= {{XLEN{1'b0}}, w_mag1};
                            r_opnd   <= w_mag2;
                            r_neg_hi <= w_s1;
                        end else begin
                            r_acc    <= {{XLEN{1'b0}}, w_mag2};
                            r_opnd   <= w_mag1;
                            r_neg_hi <= w_s1 ^ w_s2;
                        end
                        if (w_special) begin
                            r_wdata  <= w_special_res;
                            r_wd_out <= wd_i;
                        end else if (w_hit) begin
                            r_wdata  <= w_hit_res;
                            r_wd_out <= wd_i;
                        end
                    end
                end
                MD_CALC: begin
                    r_acc <= w_step_acc;
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                MD_FIXUP: begin
                    if (!flush_i) begin
                        r_acc    <= w_fix_full;
                        r_wdata  <= pick_result(r_op, w_fix_full);
                        r_wd_out <= r_wd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed self-checking bench for ex_muldiv (XLEN=32).
// Expected results come from 64-bit integer arithmetic; latency from the op class rules.
module tb_ex_muldiv;

    localparam int XLEN = 32;
`ifdef EX_MD_RESULT_CACHE_EN
    localparam int CACHE_LAT = 1;
`else
    localparam int CACHE_LAT = XLEN + 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        start_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = '0;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic        busy_o;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference cache state: last completed (non-special, non-hit) op.
    logic        mc_valid = 1'b0;
    logic [31:0] mc_a, mc_b;
    int          mc_cls;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .start_i (start_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .reg1_i  (reg1_i),
        .reg2_i  (reg2_i),
        .wd_i    (wd_i),
        .wreg_i  (wreg_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .wd_o    (wd_o),
        .wreg_o  (wreg_o),
        .wdata_o (wdata_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Signedness class: 0 unsigned mul, 1 signed mul, 2 signed*unsigned mul, 3 signed div, 4 unsigned div.
    function automatic int op_cls(input logic [2:0] op);
        case (op)
            3'd1:       return 1;
            3'd2:       return 2;
            3'd4, 3'd6: return 3;
            3'd5, 3'd7: return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic model_hit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_MD_RESULT_CACHE_EN
        return mc_valid && a == mc_a && b == mc_b &&
               (op_cls(op) == mc_cls || (op == 3'd0 && mc_cls <= 2));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Issue one op, wait (bounded) for valid_o, check result, timing and pulse shape.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] got, output int lat);
        logic [31:0] exp;
        int          lat_exp;
        logic        special, hit, wr;
        logic [4:0]  wd;
        exp     = ref_md(op, a, b);
        special = is_special(op, a, b);
        hit     = model_hit(op, a, b);
        lat_exp = (special || hit) ? 1 : XLEN + 2;
        wd      = 5'($urandom_range(0, 31));
        wr      = 1'($urandom_range(0, 1));
        @(negedge clk);
        check($sformatf("ready_idle op%0d", op), ready_o, 1);
        start_i = 1'b1; op_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        if (lat_exp > 1) check($sformatf("busy op%0d", op), busy_o, 1);
        while (!valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d %h,%h", op, a, b), lat, lat_exp);
        check($sformatf("wdata op%0d %h,%h", op, a, b), wdata_o, exp);
        check($sformatf("wd op%0d", op), wd_o, wd);
        check($sformatf("wreg op%0d", op), wreg_o, wr);
        got = wdata_o;
        if (!special && !hit) begin
            mc_valid = 1'b1; mc_a = a; mc_b = b; mc_cls = op_cls(op);
        end
        @(negedge clk);
        check($sformatf("valid_pulse op%0d", op), valid_o, 0);
        check($sformatf("wreg_low op%0d", op), wreg_o, 0);
        check($sformatf("ready_back op%0d", op), ready_o, 1);
        check($sformatf("wdata_hold op%0d", op), wdata_o, exp);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] got, a, b;
        int          lat, seen;
        logic [2:0]  op;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_wd", wd_o, 0);
        check("rst_wdata", wdata_o, 0);
        rst = 1'b0;

        // Directed values with literal expectations.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, got, lat);
        check("mul_7_m3", got, 32'hFFFF_FFEB);
        check("mul_lat", lat, 34);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat);
        check("mulhu_max", got, 32'hFFFF_FFFE);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, got, lat);
        check("mulh_min", got, 32'h4000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, got, lat);
        check("mulhsu_m1_2", got, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, got, lat);
        check("div_m7_2", got, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, got, lat);
        check("rem_m7_2", got, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, got, lat);
        check("divu_100_7", got, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, got, lat);
        check("remu_100_7", got, 32'd2);
        run_op(3'd5, 32'd5, 32'd0, got, lat);
        check("divu_by0", got, 32'hFFFF_FFFF);
        check("divu_by0_lat", lat, 1);
        run_op(3'd6, 32'd5, 32'd0, got, lat);
        check("rem_by0", got, 32'd5);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, got, lat);
        check("div_ovf", got, 32'h8000_0000);
        check("div_ovf_lat", lat, 1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, got, lat);
        check("rem_ovf", got, 32'd0);

        // Cache scenario: MULH then MUL on the same operands.
        run_op(3'd1, 32'd3, 32'd5, got, lat);
        run_op(3'd0, 32'd3, 32'd5, got, lat);
        check("cache_mul_val", got, 32'd15);
        check("cache_mul_lat", lat, CACHE_LAT);

        // Flush mid-CALC with a competing start: no result, no accept.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd4; reg1_i = 32'd1000; reg2_i = 32'd7; wd_i = 5'd9; wreg_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        flush_i = 1'b1; start_i = 1'b1; op_i = 3'd5;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        check("flush_ready", ready_o, 1);
        check("flush_busy", busy_o, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        check("flush_no_valid", seen, 0);
        // The flushed op never reached the cache, so this must recompute.
        run_op(3'd4, 32'd1000, 32'd7, got, lat);
        check("after_flush_lat", lat, 34);

        // Flush together with start in IDLE: not accepted.
        @(negedge clk);
        flush_i = 1'b1; start_i = 1'b1; op_i = 3'd0; reg1_i = 32'd2; reg2_i = 32'd3;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        check("idle_flush_busy", busy_o, 0);

        // Flush in DONE suppresses the pulse.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; reg1_i = 32'd5; reg2_i = 32'd0; wreg_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b1;
        #1;
        check("done_flush_valid", valid_o, 0);
        check("done_flush_wreg", wreg_o, 0);
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        check("done_flush_ready", ready_o, 1);

        // Flush in DONE of a full-latency op: the result must not be cached.
        a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd3; reg1_i = a; reg2_i = b;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (33) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check("late_flush_valid", valid_o, 0);
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        run_op(3'd3, a, b, got, lat);
        check("late_flush_recompute", lat, 34);

        // Randomized ops, occasionally repeating operands.
        a = 32'd0; b = 32'd0;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                a = rand_opnd();
                b = rand_opnd();
            end
            run_op(op, a, b, got, lat);
        end

        // Reset mid-op discards the op and clears the cache.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; reg1_i = 32'd3; reg2_i = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mc_valid = 1'b0;
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_wdata", wdata_o, 0);
        check("mid_rst_wd", wd_o, 0);
        run_op(3'd1, 32'd3, 32'd5, got, lat);
        check("post_rst_lat", lat, 34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
